clint: RTL and testbench

Core-local interruptor: the memory-mapped source of the machine software and timer interrupts that the CSR unit samples as `swint` and `trint`. It holds `msip`, `mtimecmp` and a free-running 64-bit `mtime`, and serves them on a single-outstanding request/response bus port. It sits beside the data-memory path, behind the address-range decode of the core's data bus.

---
 rtl/clint.sv | 140 ++++++++++++++
 tb/tb_clint.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clint.sv
// clint: core-local interruptor serving msip, mtimecmp and a free-running
// 64-bit mtime on a single-outstanding request/response port. It drives the
// machine software (swint) and timer (trint) interrupt lines.
// Optional build macro: CLINT_MTIME_WR_EN makes mtime writable, and a write
// also clears the prescaler. Without it, mtime writes are acknowledged but
// have no effect.
module clint #(
    parameter logic [63:0] BASE     = 64'h0200_0000,
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [7:0]  req_strobe,
    input  logic [63:0] req_data,
    output logic        resp_ok,
    output logic [63:0] resp_data,
    output logic        swint,
    output logic        trint
);

    localparam logic [12:0] W_MSIP   = 13'h0000;
    localparam logic [12:0] W_CMP    = 13'h0800;
    localparam logic [12:0] W_TIME   = 13'h17FF;
    localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);

    typedef enum logic {IDLE, RESP} state_t;

    state_t      state, state_nx;
    logic        accept;
    logic        in_range, sel_msip, sel_cmp, sel_time;
    logic        wr_msip, wr_cmp, wr_time;
    logic        tick;
    logic [15:0] div;
    logic [63:0] mtime, mtimecmp;
    logic        msip;
    logic [63:0] rdata;
    logic        unused_addr_lsbs;

    function automatic logic [63:0] merge_bytes(input logic [63:0] old_v,
                                                input logic [63:0] new_v,
                                                input logic [7:0]  strb);
        logic [63:0] r;
        r = old_v;
        for (int unsigned i = 0; i < 8; i++) begin
            if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    assign unused_addr_lsbs = ^req_addr[2:0];

    assign in_range = (req_addr[63:16] == BASE[63:16]);
    assign sel_msip = in_range && (req_addr[15:3] == W_MSIP);
    assign sel_cmp  = in_range && (req_addr[15:3] == W_CMP);
    assign sel_time = in_range && (req_addr[15:3] == W_TIME);

    assign wr_msip = accept && req_write && sel_msip;
    assign wr_cmp  = accept && req_write && sel_cmp;
`ifdef CLINT_MTIME_WR_EN
    assign wr_time = accept && req_write && sel_time;
`else
    assign wr_time = 1'b0;
`endif

    assign tick  = (div == DIV_LAST);
    assign swint = msip;
    assign trint = (mtime >= mtimecmp);

    // Bus state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next state: accept in IDLE, one response cycle, back to IDLE.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        resp_ok  = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept   = 1'b1;
                    state_nx = RESP;
                end
            end
            RESP: begin
                resp_ok  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Read mux over the current (pre-update) register values.
    always_comb begin
        rdata = '0;
        if (sel_msip)      rdata = {63'b0, msip};
        else if (sel_cmp)  rdata = mtimecmp;
        else if (sel_time) rdata = mtime;
    end

    // Response data captured at the accepting edge, cleared after the pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)            resp_data <= '0;
        else if (accept)         resp_data <= req_write ? '0 : rdata;
        else if (state == RESP)  resp_data <= '0;
    end

    // Prescaler and mtime; a write to mtime overrides a coincident tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div   <= '0;
            mtime <= '0;
        end else if (wr_time) begin
            div   <= '0;
            mtime <= merge_bytes(mtime, req_data, req_strobe);
        end else if (tick) begin
            div   <= '0;
            mtime <= mtime + 64'd1;
        end else begin
            div   <= div + 16'd1;
        end
    end

    // Software-visible compare and software-interrupt registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mtimecmp <= '1;
            msip     <= 1'b0;
        end else begin
            if (wr_cmp)                  mtimecmp <= merge_bytes(mtimecmp, req_data, req_strobe);
            if (wr_msip && req_strobe[0]) msip    <= req_data[0];
        end
    end

endmodule

// File: tb/tb_clint.sv
// tb_clint: randomized self-checking bench for clint. Two instances share the
// request bus (TICK_DIV 1 and 4); mtime is modelled as an anchor value plus
// elapsed edges divided by the tick divisor.
module tb_clint;

    localparam logic [63:0] BASE = 64'h0200_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        v1 = 1'b0, v4 = 1'b0;
    logic        req_write = 1'b0;
    logic [63:0] req_addr = '0;
    logic [7:0]  req_strobe = '0;
    logic [63:0] req_data = '0;
    logic        ok1, ok4, sw1, sw4, tr1, tr4;
    logic [63:0] rd1, rd4;

    int n_cmp = 0;
    int n_bad = 0;

    longint unsigned edges = 0;

    logic [63:0]     m_cmp[2];
    logic            m_msip[2];
    logic [63:0]     m_anc_val[2];
    longint unsigned m_anc_edge[2];
    longint unsigned m_td[2] = '{64'd1, 64'd4};

    clint #(.BASE(BASE), .TICK_DIV(1)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(v1), .req_write(req_write),
        .req_addr(req_addr), .req_strobe(req_strobe), .req_data(req_data),
        .resp_ok(ok1), .resp_data(rd1), .swint(sw1), .trint(tr1)
    );

    clint #(.BASE(BASE), .TICK_DIV(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .req_valid(v4), .req_write(req_write),
        .req_addr(req_addr), .req_strobe(req_strobe), .req_data(req_data),
        .resp_ok(ok4), .resp_data(rd4), .swint(sw4), .trint(tr4)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) edges <= 0;
        else          edges <= edges + 1;
    end

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cmp[i]      = '1;
            m_msip[i]     = 1'b0;
            m_anc_val[i]  = '0;
            m_anc_edge[i] = 0;
        end
    endfunction

    // mtime held in the register after n edges since reset release.
    function automatic logic [63:0] mt(input int i, input longint unsigned n);
        return m_anc_val[i] + 64'((n - m_anc_edge[i]) / m_td[i]);
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] d,
                                          input logic [7:0] s);
        logic [63:0] r;
        r = o;
        for (int b = 0; b < 8; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [63:0] model_read(input int i, input logic [63:0] a,
                                               input longint unsigned nacc);
        if (a[63:16] != BASE[63:16]) return '0;
        case (a[15:3])
            13'h0000: return {63'b0, m_msip[i]};
            13'h0800: return m_cmp[i];
            13'h17FF: return mt(i, nacc - 1);
            default:  return '0;
        endcase
    endfunction

    function automatic void model_write(input int i, input logic [63:0] a, input logic [7:0] s,
                                        input logic [63:0] d, input longint unsigned nacc);
        if (a[63:16] != BASE[63:16]) return;
        case (a[15:3])
            13'h0000: if (s[0]) m_msip[i] = d[0];
            13'h0800: m_cmp[i] = merge(m_cmp[i], d, s);
            13'h17FF: begin
`ifdef CLINT_MTIME_WR_EN
                m_anc_val[i]  = merge(mt(i, nacc - 1), d, s);
                m_anc_edge[i] = nacc;
`endif
            end
            default: ;
        endcase
    endfunction

    // One transaction on instance i; returns what was seen in the response
    // cycle plus the model's expected read data. Updates the model.
    task automatic bus(input int i, input logic w, input logic [63:0] a, input logic [7:0] s,
                       input logic [63:0] d, output logic ok, output logic [63:0] rd,
                       output logic sw, output logic tr, output longint unsigned nacc,
                       output logic [63:0] exp_rd);
        @(posedge clk); #1;
        req_write = w; req_addr = a; req_strobe = s; req_data = d;
        if (i == 0) v1 = 1'b1; else v4 = 1'b1;
        @(posedge clk); #1;
        nacc = edges;
        ok = (i == 0) ? ok1 : ok4;
        rd = (i == 0) ? rd1 : rd4;
        sw = (i == 0) ? sw1 : sw4;
        tr = (i == 0) ? tr1 : tr4;
        v1 = 1'b0; v4 = 1'b0;
        exp_rd = w ? 64'd0 : model_read(i, a, nacc);
        if (w) model_write(i, a, s, d, nacc);
    endtask

    task automatic test_reset();
        logic ok, sw, tr; logic [63:0] rd, ex; longint unsigned na;
        reset_n = 1'b1; #1 reset_n = 1'b0; #2;
        n_cmp++; if ({ok1, ok4, sw1, sw4, tr1, tr4} !== 6'b0) begin
            n_bad++; $display("FAIL reset_flags: got %b want 000000", {ok1, ok4, sw1, sw4, tr1, tr4}); end
        n_cmp++; if ((rd1 | rd4) !== 64'd0) begin
            n_bad++; $display("FAIL reset_data: got %h/%h want 0", rd1, rd4); end
        repeat (3) @(posedge clk); #1;
        n_cmp++; if ({ok1, sw1, tr1, ok4, sw4, tr4} !== 6'b0) begin
            n_bad++; $display("FAIL reset_held: got %b want 000000", {ok1, sw1, tr1, ok4, sw4, tr4}); end
        reset_n = 1'b1;
        model_reset();
        repeat (9) @(posedge clk);
        bus(0, 1'b0, BASE + 64'hBFF8, 8'h00, 64'd0, ok, rd, sw, tr, na, ex);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL first_read_ok: got %b want 1", ok); end
        n_cmp++; if (rd !== 64'd10) begin n_bad++; $display("FAIL first_read_mtime: got %0d want 10", rd); end
        n_cmp++; if (rd !== ex) begin n_bad++; $display("FAIL first_read_model: got %0d want %0d", rd, ex); end
        n_cmp++; if ({sw, tr} !== 2'b00) begin n_bad++; $display("FAIL first_read_irq: got %b want 00", {sw, tr}); end
    endtask

    task automatic test_timer_cmp();
        logic ok, sw, tr, rose, exp_tr; logic [63:0] rd, ex; longint unsigned na;
        bus(0, 1'b1, BASE + 64'h4000, 8'hFF, 64'd40, ok, rd, sw, tr, na, ex);
        n_cmp++; if (tr !== (mt(0, na) >= 64'd40)) begin
            n_bad++; $display("FAIL cmp40_trint: got %b want %b", tr, mt(0, na) >= 64'd40); end
        rose = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            exp_tr = (mt(0, edges) >= m_cmp[0]);
            n_cmp++; if (tr1 !== exp_tr) begin
                n_bad++; $display("FAIL trint_track: cycle %0d got %b want %b", k, tr1, exp_tr); end
            if (tr1 === 1'b1) rose = 1'b1;
        end
        n_cmp++; if (rose !== 1'b1) begin n_bad++; $display("FAIL trint_rise: got %b want 1", rose); end
        bus(0, 1'b1, BASE + 64'h4000, 8'hFF, '1, ok, rd, sw, tr, na, ex);
        n_cmp++; if ({ok, tr} !== 2'b10) begin
            n_bad++; $display("FAIL trint_clear: got ok,trint=%b want 10", {ok, tr}); end
        n_cmp++; if (rd !== 64'd0) begin n_bad++; $display("FAIL write_resp_data: got %h want 0", rd); end
    endtask

    task automatic test_msip();
        logic ok, sw, tr; logic [63:0] rd, ex; longint unsigned na;
        bus(0, 1'b1, BASE, 8'hFF, 64'h3, ok, rd, sw, tr, na, ex);
        n_cmp++; if (sw !== 1'b1) begin n_bad++; $display("FAIL msip_set: got %b want 1", sw); end
        bus(0, 1'b0, BASE + 64'h4, 8'h00, 64'd0, ok, rd, sw, tr, na, ex);
        n_cmp++; if (rd !== 64'h1) begin n_bad++; $display("FAIL msip_read: got %h want 1", rd); end
        bus(0, 1'b1, BASE, 8'hFE, 64'h0, ok, rd, sw, tr, na, ex);
        n_cmp++; if (sw !== 1'b1) begin n_bad++; $display("FAIL msip_strobe: got %b want 1", sw); end
        bus(0, 1'b1, BASE, 8'h01, 64'h0, ok, rd, sw, tr, na, ex);
        n_cmp++; if (sw !== 1'b0) begin n_bad++; $display("FAIL msip_clear: got %b want 0", sw); end
    endtask

    task automatic test_partial();
        logic ok, sw, tr; logic [63:0] rd, ex; longint unsigned na;
        bus(0, 1'b1, BASE + 64'h4000, 8'hFF, 64'h1111_2222_3333_4444, ok, rd, sw, tr, na, ex);
        bus(0, 1'b1, BASE + 64'h4000, 8'hF0, 64'hAAAA_BBBB_0000_0000, ok, rd, sw, tr, na, ex);
        bus(0, 1'b0, BASE + 64'h4000, 8'h00, 64'd0, ok, rd, sw, tr, na, ex);
        n_cmp++; if (rd !== 64'hAAAA_BBBB_3333_4444) begin
            n_bad++; $display("FAIL partial_merge: got %h want aaaabbbb33334444", rd); end
        n_cmp++; if (tr !== (mt(0, na) >= m_cmp[0])) begin
            n_bad++; $display("FAIL partial_trint: got %b want %b", tr, mt(0, na) >= m_cmp[0]); end
    endtask

    task automatic test_unmapped();
        logic ok, sw, tr; logic [63:0] rd, ex; longint unsigned na;
        bus(0, 1'b0, BASE + 64'h0100, 8'h00, 64'd0, ok, rd, sw, tr, na, ex);
        n_cmp++; if ({ok, rd} !== {1'b1, 64'd0}) begin
            n_bad++; $display("FAIL unmapped_read: got ok=%b data=%h want ok=1 data=0", ok, rd); end
        bus(0, 1'b1, BASE + 64'h1_0000, 8'hFF, 64'h1, ok, rd, sw, tr, na, ex);
        bus(0, 1'b1, BASE + 64'h1_4000, 8'hFF, 64'h5, ok, rd, sw, tr, na, ex);
        n_cmp++; if ({ok, sw} !== 2'b10) begin
            n_bad++; $display("FAIL out_of_range_write: got ok,swint=%b want 10", {ok, sw}); end
        bus(0, 1'b0, BASE + 64'h4000, 8'h00, 64'd0, ok, rd, sw, tr, na, ex);
        n_cmp++; if (rd !== ex) begin n_bad++; $display("FAIL out_of_range_cmp: got %h want %h", rd, ex); end
    endtask

    task automatic test_mtime_wrap();
        logic ok, sw, tr; logic [63:0] rd, ex; longint unsigned na;
        bus(1, 1'b1, BASE + 64'hBFF8, 8'hFF, '1, ok, rd, sw, tr, na, ex);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL mtime_write_ok: got %b want 1", ok); end
        for (int k = 0; k < 5; k++) begin
            bus(1, 1'b0, BASE + 64'hBFF8, 8'h00, 64'd0, ok, rd, sw, tr, na, ex);
            n_cmp++; if (rd !== ex) begin
                n_bad++; $display("FAIL mtime_wrap: read %0d got %h want %h", k, rd, ex); end
            n_cmp++; if (tr !== (mt(1, na) >= m_cmp[1])) begin
                n_bad++; $display("FAIL mtime_wrap_trint: read %0d got %b want %b", k, tr, mt(1, na) >= m_cmp[1]); end
        end
    endtask

    task automatic test_back_to_back();
        logic exp_ok; logic [63:0] ex;
        @(posedge clk); #1;
        req_write = 1'b0; req_addr = BASE + 64'hBFF8; req_strobe = '0; v1 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            exp_ok = (k % 2 == 0);
            ex = exp_ok ? mt(0, edges - 1) : 64'd0;
            n_cmp++; if ({ok1, rd1} !== {exp_ok, ex}) begin
                n_bad++; $display("FAIL back_to_back: cycle %0d got ok=%b data=%h want ok=%b data=%h",
                                  k, ok1, rd1, exp_ok, ex); end
        end
        v1 = 1'b0;
    endtask

    task automatic test_random();
        logic ok, sw, tr, w; logic [63:0] rd, ex, a, d; logic [7:0] s;
        longint unsigned na; int i;
        logic [63:0] offs[7] = '{64'h0, 64'h4000, 64'hBFF8, 64'h0100, 64'h8000, 64'h1_4000, 64'hBFF0};
        for (int k = 0; k < 250; k++) begin
            i = int'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            a = BASE + offs[$urandom_range(0, 6)] + 64'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) a = a ^ (64'd1 << $urandom_range(16, 63));
            s = 8'($urandom);
            d = ($urandom_range(0, 1) == 1) ? mt(i, edges) + 64'($urandom_range(0, 30))
                                            : {$urandom, $urandom};
            bus(i, w, a, s, d, ok, rd, sw, tr, na, ex);
            n_cmp++; if ({ok, rd} !== {1'b1, ex}) begin
                n_bad++; $display("FAIL random_resp: #%0d dut%0d w=%b a=%h got ok=%b data=%h want ok=1 data=%h",
                                  k, i, w, a, ok, rd, ex); end
            n_cmp++; if ({sw, tr} !== {m_msip[i], mt(i, na) >= m_cmp[i]}) begin
                n_bad++; $display("FAIL random_irq: #%0d dut%0d got sw,tr=%b want %b", k, i, {sw, tr},
                                  {m_msip[i], mt(i, na) >= m_cmp[i]}); end
        end
    endtask

    task automatic test_reset_in_resp();
        logic ok, sw, tr; logic [63:0] rd, ex; longint unsigned na;
        @(posedge clk); #1;
        req_write = 1'b0; req_addr = BASE + 64'hBFF8; v1 = 1'b1;
        @(posedge clk); #1;
        v1 = 1'b0;
        n_cmp++; if (ok1 !== 1'b1) begin n_bad++; $display("FAIL resp_before_reset: got %b want 1", ok1); end
        reset_n = 1'b0; #1;
        n_cmp++; if ({ok1, rd1, sw1, tr1} !== 67'd0) begin
            n_bad++; $display("FAIL reset_in_resp: got ok=%b data=%h sw=%b tr=%b want all 0", ok1, rd1, sw1, tr1); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_reset();
        bus(0, 1'b0, BASE + 64'hBFF8, 8'h00, 64'd0, ok, rd, sw, tr, na, ex);
        n_cmp++; if ({ok, rd} !== {1'b1, ex}) begin
            n_bad++; $display("FAIL reissue_after_reset: got ok=%b data=%h want ok=1 data=%h", ok, rd, ex); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_timer_cmp();
        test_msip();
        test_partial();
        test_unmapped();
        test_mtime_wrap();
        test_back_to_back();
        test_random();
        test_reset_in_resp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
